// File: rtl/irq_return_ctrl.sv
// -----------------------------------------------------------------------------
// irq_return_ctrl
// Interrupt entry/return sequencer for the 5-stage core.
//   Entry : IDLE -> CAPTURE -> DRAIN (FLUSH_CYCLES) -> VECTOR -> HANDLER
//   Return: HANDLER --rfe--> RET_DRAIN (FLUSH_CYCLES) -> RETURN -> IDLE
//
// Parameters
//   HANDLER_VEC   fetch address of the handler (must be below 32'h0001_0000)
//   FLUSH_CYCLES  pipeline drain length, 1..15
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   irq           level-sensitive interrupt request
//   rfe           decoded return-from-exception (one-cycle pulse)
//   iar_pc        saved resume PC from the interrupt address register
//   irq_ack       one-cycle acknowledge to the requesting device
//   exception     one-cycle capture strobe to the interrupt address register
//   stall_req     hold the IF/ID front end
//   flush         kill in-flight instructions
//   pc_load       PC override valid
//   pc_load_addr  PC override value (0 when pc_load is low)
//   in_handler    high while the handler executes
//   ie            interrupt enable
//
// Every output is a flop loaded from the next-state decode, so the outputs
// always describe the current state and no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module irq_return_ctrl #(
    parameter logic [31:0] HANDLER_VEC  = 32'h0000_8000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        irq,
    input  logic        rfe,
    input  logic [31:0] iar_pc,
    output logic        irq_ack,
    output logic        exception,
    output logic        stall_req,
    output logic        flush,
    output logic        pc_load,
    output logic [31:0] pc_load_addr,
    output logic        in_handler,
    output logic        ie
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CAPTURE   = 3'd1,
        S_DRAIN     = 3'd2,
        S_VECTOR    = 3'd3,
        S_HANDLER   = 3'd4,
        S_RET_DRAIN = 3'd5,
        S_RETURN    = 3'd6
    } state_t;

    localparam logic [3:0] LP_CNT_LAST = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic [31:0] r_ret_pc;
    logic [31:0] w_ret_pc_next;
    logic        r_ie;
    logic        w_ie_next;

    logic        w_irq_ack;
    logic        w_exception;
    logic        w_stall_req;
    logic        w_flush;
    logic        w_pc_load;
    logic [31:0] w_pc_load_addr;
    logic        w_in_handler;

    logic        r_irq_ack;
    logic        r_exception;
    logic        r_stall_req;
    logic        r_flush;
    logic        r_pc_load;
    logic [31:0] r_pc_load_addr;
    logic        r_in_handler;

    // Next-state, drain counter, return PC and interrupt-enable update.
    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt;
        w_ret_pc_next = r_ret_pc;
        w_ie_next     = r_ie;
        case (r_state)
            S_IDLE: begin
                // rfe is deliberately not looked at here.
                if (irq) begin
                    w_next = S_CAPTURE;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CAPTURE: begin
                w_next     = S_DRAIN;
                w_cnt_next = 4'd0;
                w_ie_next  = 1'b0;
            end
            S_DRAIN: begin
                w_cnt_next = r_cnt + 4'd1;
                if (r_cnt == LP_CNT_LAST) begin
                    w_next = S_VECTOR;
                end else begin
                    w_next = S_DRAIN;
                end
            end
            S_VECTOR: begin
                w_next = S_HANDLER;
            end
            S_HANDLER: begin
                // A held irq level is not serviced until we are back in IDLE;
                // rfe therefore always wins a same-edge tie.
                if (rfe) begin
                    w_next        = S_RET_DRAIN;
                    w_ret_pc_next = iar_pc;
                    w_cnt_next    = 4'd0;
                end else begin
                    w_next = S_HANDLER;
                end
            end
            S_RET_DRAIN: begin
                w_cnt_next = r_cnt + 4'd1;
                if (r_cnt == LP_CNT_LAST) begin
                    w_next = S_RETURN;
                end else begin
                    w_next = S_RET_DRAIN;
                end
            end
            S_RETURN: begin
                w_next    = S_IDLE;
                w_ie_next = 1'b1;
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = 4'd0;
                w_ie_next  = 1'b1;
            end
        endcase
    end

    // Output decode of the state being entered, captured into output flops.
    always_comb begin
        w_irq_ack      = 1'b0;
        w_exception    = 1'b0;
        w_stall_req    = 1'b0;
        w_flush        = 1'b0;
        w_pc_load      = 1'b0;
        w_pc_load_addr = 32'h0000_0000;
        w_in_handler   = 1'b0;
        case (w_next)
            S_IDLE: begin
                w_stall_req = 1'b0;
            end
            S_CAPTURE: begin
                w_irq_ack   = 1'b1;
                w_exception = 1'b1;
                w_stall_req = 1'b1;
            end
            S_DRAIN: begin
                w_stall_req = 1'b1;
                w_flush     = 1'b1;
            end
            S_VECTOR: begin
                w_stall_req    = 1'b1;
                w_pc_load      = 1'b1;
                w_pc_load_addr = HANDLER_VEC;
            end
            S_HANDLER: begin
                w_in_handler = 1'b1;
            end
            S_RET_DRAIN: begin
                w_stall_req  = 1'b1;
                w_flush      = 1'b1;
                w_in_handler = 1'b1;
            end
            S_RETURN: begin
                w_stall_req    = 1'b1;
                w_pc_load      = 1'b1;
                w_pc_load_addr = w_ret_pc_next;
            end
            default: begin
                w_stall_req = 1'b0;
            end
        endcase
    end

    // State, counter, return PC and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= 4'd0;
            r_ret_pc       <= 32'h0000_0000;
            r_ie           <= 1'b1;
            r_irq_ack      <= 1'b0;
            r_exception    <= 1'b0;
            r_stall_req    <= 1'b0;
            r_flush        <= 1'b0;
            r_pc_load      <= 1'b0;
            r_pc_load_addr <= 32'h0000_0000;
            r_in_handler   <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_cnt          <= w_cnt_next;
            r_ret_pc       <= w_ret_pc_next;
            r_ie           <= w_ie_next;
            r_irq_ack      <= w_irq_ack;
            r_exception    <= w_exception;
            r_stall_req    <= w_stall_req;
            r_flush        <= w_flush;
            r_pc_load      <= w_pc_load;
            r_pc_load_addr <= w_pc_load_addr;
            r_in_handler   <= w_in_handler;
        end
    end

    assign irq_ack      = r_irq_ack;
    assign exception    = r_exception;
    assign stall_req    = r_stall_req;
    assign flush        = r_flush;
    assign pc_load      = r_pc_load;
    assign pc_load_addr = r_pc_load_addr;
    assign in_handler   = r_in_handler;
    assign ie           = r_ie;

endmodule

// File: tb/tb_irq_return_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for irq_return_ctrl (FLUSH_CYCLES = 2).
// A timeline model (mode + position within the sequence) predicts the outputs
// every cycle; directed sequences additionally pin literal values.
// Flag vector order: {irq_ack, exception, stall_req, flush, pc_load,
//                     in_handler, ie}
// -----------------------------------------------------------------------------
module tb_irq_return_ctrl;

    localparam int          F   = 2;
    localparam logic [31:0] VEC = 32'h0000_8000;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        irq    = 1'b0;
    logic        rfe    = 1'b0;
    logic [31:0] iar_pc = 32'h0;
    logic        irq_ack, exception, stall_req, flush, pc_load, in_handler, ie;
    logic [31:0] pc_load_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_return_ctrl #(.HANDLER_VEC(VEC), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .reset(reset), .irq(irq), .rfe(rfe), .iar_pc(iar_pc),
        .irq_ack(irq_ack), .exception(exception), .stall_req(stall_req),
        .flush(flush), .pc_load(pc_load), .pc_load_addr(pc_load_addr),
        .in_handler(in_handler), .ie(ie)
    );

    wire [6:0] dut_flags = {irq_ack, exception, stall_req, flush, pc_load, in_handler, ie};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode 0 idle, 1 entry sequence, 2 handler, 3 return sequence;
    // m_k is the cycle index inside the entry/return sequence.
    int          m_mode = 0;
    int          m_k    = 0;
    logic [31:0] m_ret  = 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode <= 0; m_k <= 0; m_ret <= 32'h0;
        end else begin
            case (m_mode)
                0: if (irq) begin m_mode <= 1; m_k <= 0; end
                1: if (m_k == F + 1) m_mode <= 2; else m_k <= m_k + 1;
                2: if (rfe) begin m_mode <= 3; m_k <= 0; m_ret <= iar_pc; end
                3: if (m_k == F) m_mode <= 0; else m_k <= m_k + 1;
                default: m_mode <= 0;
            endcase
        end
    end

    function automatic logic [6:0] exp_flags(input int mode, input int k);
        case (mode)
            1: begin
                if (k == 0) return 7'b1110001;   // capture
                if (k <= F) return 7'b0011000;   // drain
                return 7'b0010100;               // vector
            end
            2: return 7'b0000010;
            3: begin
                if (k < F) return 7'b0011010;
                return 7'b0010100;
            end
            default: return 7'b0000001;
        endcase
    endfunction

    function automatic logic [31:0] exp_addr(input int mode, input int k, input logic [31:0] ret);
        if (mode == 1 && k == F + 1) return VEC;
        if (mode == 3 && k == F) return ret;
        return 32'h0;
    endfunction

    // Single compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        chk("model_flags", {25'd0, dut_flags}, {25'd0, exp_flags(m_mode, m_k)});
        chk("model_addr", pc_load_addr, exp_addr(m_mode, m_k, m_ret));
    end

    // ---------------- directed helpers ----------------
    task automatic expect_neg(input string name, input logic [6:0] f, input logic [31:0] a);
        @(negedge clk);
        chk({name, "_flags"}, {25'd0, dut_flags}, {25'd0, f});
        chk({name, "_addr"}, pc_load_addr, a);
    endtask

    // From IDLE with irq low: raise irq for one edge (or keep it) and pin the
    // full entry timeline up to the first handler cycle.
    task automatic entry_literal(input logic hold);
        @(posedge clk); #2 irq = 1'b1;
        @(posedge clk); #2 irq = hold;            // edge t sampled irq
        expect_neg("cap",     7'b1110001, 32'h0); // t+1
        expect_neg("drain1",  7'b0011000, 32'h0); // t+2
        expect_neg("drain2",  7'b0011000, 32'h0); // t+3
        expect_neg("vector",  7'b0010100, VEC);   // t+4
        expect_neg("handler", 7'b0000010, 32'h0); // t+5
    endtask

    // From HANDLER: pulse rfe with the given iar_pc, then scramble iar_pc.
    task automatic return_literal(input logic [31:0] pc);
        @(posedge clk); #2 rfe = 1'b1; iar_pc = pc;
        @(posedge clk); #2 rfe = 1'b0; iar_pc = 32'h0000_DEAD;
        expect_neg("rdrain1", 7'b0011010, 32'h0);
        expect_neg("rdrain2", 7'b0011010, 32'h0);
        expect_neg("return",  7'b0010100, pc);
        expect_neg("ret_idle", 7'b0000001, 32'h0);
    endtask

    initial begin
        // reset then idle
        repeat (3) @(posedge clk);
        expect_neg("in_reset", 7'b0000001, 32'h0);
        @(posedge clk); #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) expect_neg("idle", 7'b0000001, 32'h0);

        // entry and return
        entry_literal(1'b0);
        repeat (3) @(negedge clk);
        return_literal(32'h0001_0020);

        // held irq through handler, back-to-back re-entry
        entry_literal(1'b1);
        repeat (4) @(negedge clk);
        return_literal(32'h0000_4444);
        expect_neg("b2b_cap", 7'b1110001, 32'h0);
        repeat (6) @(negedge clk);
        irq = 1'b0;
        return_literal(32'h1234_5678);

        // stray rfe in IDLE
        @(posedge clk); #2 rfe = 1'b1; iar_pc = 32'hCAFE_0000;
        @(posedge clk); #2 rfe = 1'b0;
        for (int i = 0; i < 3; i++) expect_neg("stray_rfe", 7'b0000001, 32'h0);

        // simultaneous rfe + irq in HANDLER
        entry_literal(1'b0);
        @(posedge clk); #2 rfe = 1'b1; irq = 1'b1; iar_pc = 32'h0000_0ABC;
        @(posedge clk); #2 rfe = 1'b0;
        expect_neg("sim_rdrain1", 7'b0011010, 32'h0);
        expect_neg("sim_rdrain2", 7'b0011010, 32'h0);
        expect_neg("sim_return",  7'b0010100, 32'h0000_0ABC);
        expect_neg("sim_idle",    7'b0000001, 32'h0);
        expect_neg("sim_cap",     7'b1110001, 32'h0);
        repeat (5) @(negedge clk);
        irq = 1'b0;
        return_literal(32'h0000_0100);

        // reset mid-DRAIN
        @(posedge clk); #2 irq = 1'b1;
        @(posedge clk); #2 irq = 1'b0;
        @(posedge clk); #2 reset = 1'b0;
        #1;
        chk("rst_drain_flags", {25'd0, dut_flags}, 32'h0000_0001);
        chk("rst_drain_addr", pc_load_addr, 32'h0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        entry_literal(1'b0);

        // reset mid-RET_DRAIN
        @(posedge clk); #2 rfe = 1'b1; iar_pc = 32'h0000_7770;
        @(posedge clk); #2 rfe = 1'b0;
        #1;
        chk("pre_rst_flush", {31'd0, flush}, 32'h1);
        reset = 1'b0;
        #1;
        chk("rst_rdrain_flags", {25'd0, dut_flags}, 32'h0000_0001);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        entry_literal(1'b0);
        return_literal(32'h0000_2000);

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            irq    = ($urandom_range(0, 3) == 0);
            rfe    = ($urandom_range(0, 4) == 0);
            iar_pc = $urandom;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 199) == 0) reset = 1'b0;
        end
        @(posedge clk); #2 reset = 1'b1; irq = 1'b0; rfe = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_return_ctrl.md
# irq_return_ctrl

Interrupt entry/return sequencer for the 5-stage core. It accepts an external interrupt request and pulses `exception` so the interrupt address register captures the resume PC. It then drains the pipeline and redirects fetch to the handler vector. On a decoded return-from-exception (`rfe`) it performs the opposite sequence, draining again and reloading fetch with the saved PC from the interrupt address register.

## Interface
Parameters:
- `HANDLER_VEC`, 32'h0000_8000, fetch address of the interrupt handler; must lie below 32'h0001_0000.
- `FLUSH_CYCLES`, 2, pipeline drain length in cycles; legal range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq`  in  1  level-sensitive external interrupt request.
- `rfe`  in  1  decoded return-from-exception in ID; one-cycle pulse.
- `iar_pc`  in  32  saved resume PC from the interrupt address register.
- `irq_ack`  out  1  one-cycle acknowledge to the requesting device.
- `exception`  out  1  one-cycle capture strobe to the interrupt address register.
- `stall_req`  out  1  hold the IF/ID front end.
- `flush`  out  1  kill in-flight instructions.
- `pc_load`  out  1  PC override valid.
- `pc_load_addr`  out  32  PC override value; 0 when `pc_load`=0.
- `in_handler`  out  1  high while the handler is executing.
- `ie`  out  1  interrupt enable.

## Operation
- Single FSM with states IDLE, CAPTURE, DRAIN, VECTOR, HANDLER, RET_DRAIN, RETURN.
- There is a 4-bit drain counter `cnt` and a 32-bit return register `ret_pc`.
- All outputs are decoded from state and registers only. No combinational path runs from any input to any output.
- IDLE: `ie`=1. `irq`=1 -> CAPTURE. `rfe` is ignored.
- CAPTURE (1 cycle): `exception`=1, `irq_ack`=1, `stall_req`=1. `ie` clears on exit. `cnt`<=0. -> DRAIN.
- DRAIN: `stall_req`=1, `flush`=1. `cnt` increments each cycle. When `cnt`==FLUSH_CYCLES-1 -> VECTOR.
- VECTOR (1 cycle): `pc_load`=1, `pc_load_addr`=HANDLER_VEC, `stall_req`=1. -> HANDLER.
- HANDLER: `in_handler`=1, `ie`=0. `irq` is ignored; a level still held stays pending until IDLE. On `rfe`=1, `ret_pc`<=`iar_pc` sampled that cycle, `cnt`<=0, -> RET_DRAIN.
- RET_DRAIN: `stall_req`=1, `flush`=1, `in_handler`=1. Counts like DRAIN. -> RETURN.
- RETURN (1 cycle): `pc_load`=1, `pc_load_addr`=`ret_pc`, `stall_req`=1. `ie` sets on exit. -> IDLE.
- `rfe` outside HANDLER has no effect. `iar_pc` changes outside the `rfe` sampling cycle have no effect.
- Reset (`reset`=0, any state, any cycle) immediately forces:
  - state IDLE, `cnt`=0, `ret_pc`=0, `ie`=1;
  - every other output 0 (`pc_load_addr`=0).
- After reset release, the first rising edge with `irq`=1 moves to CAPTURE.

## Timing
- Let edge t be the IDLE edge that samples `irq`=1. Let F=FLUSH_CYCLES.
- Interrupt entry:
  - CAPTURE occupies cycle t+1, so `exception`/`irq_ack` are high exactly one cycle.
  - DRAIN occupies cycles t+2..t+1+F.
  - VECTOR occupies cycle t+2+F.
  - HANDLER begins at t+3+F.
  - Latency from `irq` sampled to `pc_load` = F+2 cycles.
- Return: from the edge sampling `rfe`, RET_DRAIN lasts F cycles, RETURN is the next cycle, and IDLE follows. Latency from `rfe` to `pc_load` = F+1 cycles.
- Back-to-back: `irq` held high through RETURN is sampled on the first IDLE edge, giving exactly one IDLE cycle between RETURN and the next CAPTURE.
- With F=1, DRAIN and RET_DRAIN each last exactly 1 cycle.
- `irq` and `rfe` asserted on the same edge in HANDLER: `rfe` wins; `irq` is serviced after return.

## Test plan
- Reset then idle: `reset` low 3 cycles with `irq`=0 -> all outputs 0, `ie`=1, state IDLE; no `pc_load` for 10 cycles.
- Entry, F=2: `irq` high at edge t -> `exception`=`irq_ack`=1 at t+1 only; `flush`=1 at t+2, t+3; `pc_load`=1 with `pc_load_addr`=32'h0000_8000 at t+4; `in_handler`=1 from t+5; `ie`=0.
- Return: in HANDLER, pulse `rfe` with `iar_pc`=32'h0001_0020, then change `iar_pc` to 32'h0000_DEAD -> `flush` 2 cycles; `pc_load_addr`=32'h0001_0020 at cycle 3 after `rfe`; IDLE and `ie`=1 next.
- Held `irq` during handler plus back-to-back: `irq` stays high throughout -> no second `exception` inside HANDLER; second CAPTURE exactly 2 cycles after RETURN.
- Stray `rfe` in IDLE and simultaneous `rfe`+`irq` in HANDLER: stray `rfe` -> no output change; simultaneous case -> RET_DRAIN entered, no `irq_ack` until after RETURN.
- Reset mid-DRAIN and mid-RET_DRAIN: `reset` low asynchronously -> `flush`/`stall_req` drop in the same cycle, `ie`=1; after release, `irq`=1 restarts a full F+2 entry sequence.
